// File: rtl/cix_seq.sv
// Multi-cycle bit-count engine: walks a wide operand one chunk per clock through a
// combinational cix counter, accumulating the per-chunk counts with early exit.

module cix #(
    parameter int ORDER = 3
) (
    input  logic [2:0]            i_op,
    input  logic [(1<<ORDER)-1:0] i_chunk,
    output logic [ORDER:0]        o_count,
    output logic                  o_all
);
    localparam int W  = 1 << ORDER;
    localparam int CW = ORDER + 1;

    logic [W-1:0]  w_match;
    logic          w_legal;
    logic [CW-1:0] w_cnt;
    logic          w_run;

    // Odd opcodes count zeros, so invert first and every op becomes a count of ones.
    assign w_match = i_op[0] ? ~i_chunk : i_chunk;
    assign w_legal = (i_op[2:1] != 2'b00);

    always_comb begin
        w_cnt = '0;
        w_run = 1'b1;
        for (int i = 0; i < W; i++) begin
            case (i_op[2:1])
                2'b01: begin
                    if (w_run && w_match[i]) w_cnt = w_cnt + CW'(1);
                    else w_run = 1'b0;
                end
                2'b10: begin
                    if (w_run && w_match[W-1-i]) w_cnt = w_cnt + CW'(1);
                    else w_run = 1'b0;
                end
                2'b11: w_cnt = w_cnt + CW'(w_match[i]);
                default: w_cnt = '0;
            endcase
        end
    end

    assign o_count = w_cnt;
    assign o_all   = w_legal & (&w_match);
endmodule

module cix_seq #(
    parameter int WORD_ORDER  = 5,
    parameter int CHUNK_ORDER = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op,
    input  logic [(1<<WORD_ORDER)-1:0] in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_ORDER:0]       out,
    output logic                      all
);
    localparam int W    = 1 << WORD_ORDER;
    localparam int C    = 1 << CHUNK_ORDER;
    localparam int N    = 1 << (WORD_ORDER - CHUNK_ORDER);
    localparam int AW   = WORD_ORDER + 1;
    localparam int IDXW = (WORD_ORDER > CHUNK_ORDER) ? (WORD_ORDER - CHUNK_ORDER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    logic [2:0]      r_op;
    logic [W-1:0]    r_word;
    logic [AW-1:0]   r_acc;
    logic [IDXW-1:0] r_idx;
    logic            r_allAcc;
    logic [AW-1:0]   r_out;
    logic            r_all;

    logic [C-1:0]           w_chunk;
    logic [CHUNK_ORDER:0]   w_cnt;
    logic                   w_chunkAll;
    logic [AW-1:0]          w_sum;
    logic                   w_leading;
    logic                   w_pop;
    logic                   w_illegal;
    logic                   w_last;
    logic [IDXW-1:0]        w_nextIdx;

    assign w_chunk = r_word[int'(r_idx) * C +: C];

    cix #(.ORDER(CHUNK_ORDER)) u_cix (
        .i_op    (r_op),
        .i_chunk (w_chunk),
        .o_count (w_cnt),
        .o_all   (w_chunkAll)
    );

    assign w_sum     = r_acc + AW'(w_cnt);
    assign w_leading = (r_op[2:1] == 2'b10);
    assign w_pop     = (r_op[2:1] == 2'b11);
    assign w_illegal = (r_op[2:1] == 2'b00);
    assign w_last    = w_leading ? (r_idx == '0) : (r_idx == IDXW'(N - 1));
    assign w_nextIdx = w_leading ? (r_idx - IDXW'(1)) : (r_idx + IDXW'(1));

    // Leading counts scan from the top chunk down; everything else scans upward.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_word   <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_allAcc <= 1'b1;
            r_out    <= '0;
            r_all    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op     <= op;
                        r_word   <= in;
                        r_acc    <= '0;
                        r_allAcc <= 1'b1;
                        r_idx    <= (op[2:1] == 2'b10) ? IDXW'(N - 1) : '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (w_illegal) begin
                        r_out   <= '0;
                        r_all   <= 1'b0;
                        r_state <= DONE;
                    end else if (w_pop) begin
                        r_allAcc <= r_allAcc & w_chunkAll;
                        if (w_last) begin
                            r_out   <= w_sum;
                            r_all   <= r_allAcc & w_chunkAll;
                            r_state <= DONE;
                        end else begin
                            r_acc <= w_sum;
                            r_idx <= w_nextIdx;
                        end
                    end else if (!w_chunkAll) begin
                        r_out   <= w_sum;
                        r_all   <= 1'b0;
                        r_state <= DONE;
                    end else if (w_last) begin
                        r_out   <= w_sum;
                        r_all   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_acc <= w_sum;
                        r_idx <= w_nextIdx;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign all       = r_all;
endmodule

// File: tb/tb_cix_seq.sv
// Directed bench for cix_seq: a vector table of single requests plus hand-written
// backpressure and reset-abort sequences.

module tb_cix_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [2:0]  opCode;
    logic [31:0] inData;
    logic        outValid;
    logic        outReady;
    logic [5:0]  outCount;
    logic        outAll;

    int nCompared = 0;
    int nFailed   = 0;

    localparam logic [2:0] OP_CTO = 3'b010, OP_CTZ = 3'b011, OP_CLO = 3'b100,
                           OP_CLZ = 3'b101, OP_PCNT = 3'b110, OP_ZCNT = 3'b111;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] data;
        int          expOut;
        int          expAll;
        int          expK;
    } vector_t;

    vector_t vecs[14];

    cix_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .op        (opCode),
        .in        (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out       (outCount),
        .all       (outAll)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns the edges from acceptance to out_valid.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] d, output int k);
        opCode  = o;
        inData  = d;
        inValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inValid = 1'b0;
        k = 0;
        while (!outValid && k < 20) begin
            @(negedge clock);
            k++;
        end
    endtask

    initial begin
        int k;
        int emitted;

        vecs[0]  = '{"ctz_0x100",      OP_CTZ,  32'h0000_0100,  8, 0, 2};
        vecs[1]  = '{"clz_zero",       OP_CLZ,  32'h0000_0000, 32, 1, 4};
        vecs[2]  = '{"clo_boundary",   OP_CLO,  32'hFF80_0000,  9, 0, 2};
        vecs[3]  = '{"pcnt_mixed",     OP_PCNT, 32'hF0F0_0001,  9, 0, 4};
        vecs[4]  = '{"pcnt_ones",      OP_PCNT, 32'hFFFF_FFFF, 32, 1, 4};
        vecs[5]  = '{"zcnt_ones",      OP_ZCNT, 32'hFFFF_FFFF,  0, 0, 4};
        vecs[6]  = '{"illegal_001",    3'b001,  32'h1234_5678,  0, 0, 1};
        vecs[7]  = '{"cto_ones",       OP_CTO,  32'hFFFF_FFFF, 32, 1, 4};
        vecs[8]  = '{"ctz_bit0",       OP_CTZ,  32'h0000_0001,  0, 0, 1};
        vecs[9]  = '{"clz_0x10000",    OP_CLZ,  32'h0001_0000, 15, 0, 2};
        vecs[10] = '{"zcnt_mixed",     OP_ZCNT, 32'h0F0F_0000, 24, 0, 4};
        vecs[11] = '{"illegal_000",    3'b000,  32'h0000_0000,  0, 0, 1};
        vecs[12] = '{"cto_low_byte",   OP_CTO,  32'h0000_00FF,  8, 0, 2};
        vecs[13] = '{"zcnt_zero",      OP_ZCNT, 32'h0000_0000, 32, 1, 4};

        reset    = 1'b1;
        inValid  = 1'b0;
        opCode   = 3'b000;
        inData   = '0;
        outReady = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_in_ready",  int'(inReady), 1);
        checkOutput("reset_out_valid", int'(outValid), 0);
        checkOutput("reset_out",       int'(outCount), 0);
        checkOutput("reset_all",       int'(outAll), 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].data, k);
            checkOutput({vecs[i].name, "_k"},   k, vecs[i].expK);
            checkOutput({vecs[i].name, "_out"}, int'(outCount), vecs[i].expOut);
            checkOutput({vecs[i].name, "_all"}, int'(outAll), vecs[i].expAll);
            checkOutput({vecs[i].name, "_in_ready_busy"}, int'(inReady), 0);
            @(negedge clock);
            checkOutput({vecs[i].name, "_back_to_idle"}, int'(inReady), 1);
        end

        // Backpressure: result must hold and new requests must be refused while stalled.
        outReady = 1'b0;
        applyStimulus(OP_CTZ, 32'h0000_0100, k);
        checkOutput("bp_k", k, 2);
        for (int c = 0; c < 5; c++) begin
            inValid = (c % 2 == 0);
            opCode  = OP_CLZ;
            inData  = 32'h0000_0000;
            @(negedge clock);
            checkOutput("bp_out_valid", int'(outValid), 1);
            checkOutput("bp_out",       int'(outCount), 8);
            checkOutput("bp_all",       int'(outAll), 0);
            checkOutput("bp_in_ready",  int'(inReady), 0);
        end
        inValid  = 1'b1;
        outReady = 1'b1;
        @(negedge clock);
        checkOutput("bp_release_idle",      int'(inReady), 1);
        checkOutput("bp_release_out_valid", int'(outValid), 0);
        checkOutput("bp_release_hold_out",  int'(outCount), 8);
        applyStimulus(OP_CLZ, 32'h0000_0000, k);
        checkOutput("bp_next_k",   k, 4);
        checkOutput("bp_next_out", int'(outCount), 32);
        checkOutput("bp_next_all", int'(outAll), 1);
        @(negedge clock);

        // Reset in the second RUN cycle of a four-chunk scan aborts it silently.
        opCode  = OP_CTZ;
        inData  = 32'h8000_0000;
        inValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inValid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort_in_ready",  int'(inReady), 1);
        checkOutput("abort_out_valid", int'(outValid), 0);
        checkOutput("abort_out",       int'(outCount), 0);
        checkOutput("abort_all",       int'(outAll), 0);
        emitted = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (outValid) emitted++;
        end
        checkOutput("abort_no_result", emitted, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule
